// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store controller: funct3 codes, FSM states
// and the access legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  // Legal funct3 for the direction, and naturally aligned for the access size.
  function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU-side request/response bus of the data-memory load/store controller.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_extend.sv
// Selects the low byte/half/word of a RAM word and sign- or zero-extends it per funct3.
module load_extend
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_BU:   result = {24'd0, word[7:0]};
      F3_HU:   result = {16'd0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// RV32I load/store initiator for a byte-addressed RAM with a combinational word read and
// full-word write; sub-word stores are done as read-modify-write.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_access_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [31:0]           mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_din,
  output logic                  mem_write_en
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic                  err_q;
  logic [2:0]            funct3_q;
  // Holds store data on accept, then the merged word (stores) or extended result (loads).
  logic [31:0]           data_q, data_d;
  logic [31:0]           load_val;
  logic                  accept;
  logic                  req_ok;

  assign accept = bus.req_valid && (state_q == StIdle);
  assign req_ok = access_ok(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .word   (mem_dout),
    .result (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (!req_ok) begin
            state_d = StResp;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = we_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (we_q) begin
      data_d = (funct3_q == F3_B) ? {mem_dout[31:8], data_q[7:0]}
                                  : {mem_dout[31:16], data_q[15:0]};
    end else begin
      data_d = load_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'd0;
      data_q   <= 32'd0;
    end else if (accept) begin
      addr_q   <= bus.req_addr;
      we_q     <= bus.req_we;
      err_q    <= ~req_ok;
      funct3_q <= bus.req_funct3;
      data_q   <= bus.req_wdata;
    end else if (state_q == StRead) begin
      data_q   <= data_d;
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle) && !rst;
    bus.rsp_valid  = 1'b0;
    bus.rsp_rdata  = 32'd0;
    bus.rsp_err    = 1'b0;
    mem_read_addr  = '0;
    mem_write_addr = '0;
    mem_din        = 32'd0;
    mem_write_en   = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRead: mem_read_addr = addr_q;
      StWrite: begin
        mem_write_en   = 1'b1;
        mem_write_addr = addr_q;
        mem_din        = data_q;
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (we_q || err_q) ? 32'd0 : data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural byte RAM and cycle-accurate checks.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mem_read_addr;
  logic [31:0] mem_dout;
  logic [11:0] mem_write_addr;
  logic [31:0] mem_din;
  logic        mem_write_en;

  dmem_access_ctrl_if #(.ADDR_WIDTH(12)) bus ();

  dmem_access_ctrl #(.ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .mem_read_addr  (mem_read_addr),
    .mem_dout       (mem_dout),
    .mem_write_addr (mem_write_addr),
    .mem_din        (mem_din),
    .mem_write_en   (mem_write_en)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [31:0] pl_data = 32'd0;
  int          wr_total = 0;
  int          rsp_total = 0;
  int          n_chk = 0;
  int          n_bad = 0;

  assign mem_dout = {ram[mem_read_addr + 12'd3], ram[mem_read_addr + 12'd2],
                     ram[mem_read_addr + 12'd1], ram[mem_read_addr]};

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr]         <= pl_data[7:0];
      ram[pl_addr + 12'd1] <= pl_data[15:8];
      ram[pl_addr + 12'd2] <= pl_data[23:16];
      ram[pl_addr + 12'd3] <= pl_data[31:24];
    end
    if (mem_write_en) begin
      ram[mem_write_addr]         <= mem_din[7:0];
      ram[mem_write_addr + 12'd1] <= mem_din[15:8];
      ram[mem_write_addr + 12'd2] <= mem_din[23:16];
      ram[mem_write_addr + 12'd3] <= mem_din[31:24];
      wr_total <= wr_total + 1;
    end
    if (bus.rsp_valid) rsp_total <= rsp_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ram_load(input logic [11:0] addr, input logic [31:0] word);
    pl_addr = addr;
    pl_data = word;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Called mid-cycle with the block idle; observes cycles N+1..N+5 after acceptance.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] wd, output int rsp_k, output logic [31:0] rdata,
                        output logic err, output int wr_k, output logic [31:0] wdin,
                        output logic [11:0] waddr, output int n_rsp, output int n_wr,
                        output logic [11:0] raddr);
    rsp_k = -1; wr_k = -1; rdata = '0; err = 1'b0; wdin = '0; waddr = '0;
    n_rsp = 0; n_wr = 0; raddr = '0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) raddr = mem_read_addr;
      if (bus.rsp_valid) begin
        n_rsp++;
        if (rsp_k < 0) begin
          rsp_k = k; rdata = bus.rsp_rdata; err = bus.rsp_err;
        end
      end
      if (mem_write_en) begin
        n_wr++;
        if (wr_k < 0) begin
          wr_k = k; wdin = mem_din; waddr = mem_write_addr;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_load(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                             input logic [31:0] exp);
    int rk, wk, nr, nw;
    logic [31:0] rd, wdn;
    logic e;
    logic [11:0] wa, ra;
    do_req(1'b0, f3, addr, 32'd0, rk, rd, e, wk, wdn, wa, nr, nw, ra);
    check({tag, ".lat"}, rk, 2);
    check({tag, ".rdata"}, rd, exp);
    check({tag, ".err"}, {31'd0, e}, 0);
    check({tag, ".raddr"}, {20'd0, ra}, {20'd0, addr});
    check({tag, ".nrsp"}, nr, 1);
    check({tag, ".nwr"}, nw, 0);
  endtask

  task automatic expect_store(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                              input logic [31:0] wd, input int exp_wk, input logic [31:0] exp_din);
    int rk, wk, nr, nw;
    logic [31:0] rd, wdn;
    logic e;
    logic [11:0] wa, ra;
    do_req(1'b1, f3, addr, wd, rk, rd, e, wk, wdn, wa, nr, nw, ra);
    check({tag, ".wr_cyc"}, wk, exp_wk);
    check({tag, ".din"}, wdn, exp_din);
    check({tag, ".waddr"}, {20'd0, wa}, {20'd0, addr});
    check({tag, ".nwr"}, nw, 1);
    check({tag, ".lat"}, rk, exp_wk + 1);
    check({tag, ".rdata"}, rd, 0);
    check({tag, ".err"}, {31'd0, e}, 0);
    check({tag, ".nrsp"}, nr, 1);
  endtask

  task automatic expect_err(input string tag, input logic we, input logic [2:0] f3,
                            input logic [11:0] addr);
    int rk, wk, nr, nw;
    logic [31:0] rd, wdn;
    logic e;
    logic [11:0] wa, ra;
    do_req(we, f3, addr, 32'hFFFF_FFFF, rk, rd, e, wk, wdn, wa, nr, nw, ra);
    check({tag, ".lat"}, rk, 1);
    check({tag, ".err"}, {31'd0, e}, 1);
    check({tag, ".rdata"}, rd, 0);
    check({tag, ".nwr"}, nw, 0);
    check({tag, ".nrsp"}, nr, 1);
  endtask

  // Alternating load/store stream for the held-valid test.
  logic        s_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]  s_f3   [4] = '{F3_W, F3_W, F3_BU, F3_B};
  logic [11:0] s_addr [4] = '{12'h010, 12'h040, 12'h011, 12'h041};
  logic [31:0] s_wd   [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h00000099};
  logic [31:0] s_exp  [4] = '{32'h02017F80, 32'h0, 32'h0000007F, 32'h0};

  task automatic set_req(input int i);
    bus.req_we     = s_we[i];
    bus.req_funct3 = s_f3[i];
    bus.req_addr   = s_addr[i];
    bus.req_wdata  = s_wd[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, accepted, n_rsp, busy;
    logic fire;
    logic [31:0] got [4];

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 12'd0; bus.req_wdata = 32'd0;

    ram_load(12'h010, 32'h02017F80);
    ram_load(12'h020, 32'hAABBCCDD);
    ram_load(12'h024, 32'h44332211);
    ram_load(12'h040, 32'h00000000);
    ram_load(12'h044, 32'h00000000);
    ram_load(12'h050, 32'h01020304);

    check("rst.ready", {31'd0, bus.req_ready}, 0);
    check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 0);
    check("rst.we", {31'd0, mem_write_en}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle.ready", {31'd0, bus.req_ready}, 1);
    check("idle.din", mem_din, 0);
    check("idle.rdata", bus.rsp_rdata, 0);
    check("idle.raddr", {20'd0, mem_read_addr}, 0);
    check("idle.waddr", {20'd0, mem_write_addr}, 0);

    // Loads with sign/zero extension
    expect_load("lb",  F3_B,  12'h010, 32'hFFFFFF80);
    expect_load("lbu", F3_BU, 12'h010, 32'h00000080);
    expect_load("lh",  F3_H,  12'h010, 32'h00007F80);
    expect_load("lw",  F3_W,  12'h010, 32'h02017F80);
    expect_load("lhs", F3_H,  12'h012, 32'h00000201);
    expect_load("lhu", F3_HU, 12'h010, 32'h00007F80);

    // Sub-word and word stores
    expect_store("sb", F3_B, 12'h020, 32'h00000011, 2, 32'hAABBCC11);
    expect_load("lw_sb", F3_W, 12'h020, 32'hAABBCC11);
    expect_store("sh", F3_H, 12'h022, 32'h12345678, 2, 32'h22115678);
    expect_store("sw", F3_W, 12'h024, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    expect_load("lw_mix", F3_W, 12'h020, 32'h5678CC11);
    expect_load("lw_sw", F3_W, 12'h024, 32'hDEADBEEF);

    // Misaligned and illegal encodings
    expect_err("e_lh31", 1'b0, F3_H, 12'h031);
    expect_err("e_lw32", 1'b0, F3_W, 12'h032);
    expect_err("e_sw33", 1'b1, F3_W, 12'h033);
    expect_err("e_f3_3", 1'b0, 3'd3, 12'h030);
    expect_err("e_sbu",  1'b1, F3_BU, 12'h030);

    // Reset during the read phase of an SB
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 12'h050; bus.req_wdata = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    w0 = wr_total; r0 = rsp_total;
    rst = 1'b1;
    #1;
    check("mrst.we", {31'd0, mem_write_en}, 0);
    check("mrst.ready", {31'd0, bus.req_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("mrst.ready_after", {31'd0, bus.req_ready}, 1);
    repeat (4) @(posedge clk);
    #1;
    check("mrst.no_write", wr_total - w0, 0);
    check("mrst.no_rsp", rsp_total - r0, 0);
    check("mrst.ram", {ram[12'h053], ram[12'h052], ram[12'h051], ram[12'h050]}, 32'h01020304);
    expect_load("mrst.lw", F3_W, 12'h010, 32'h02017F80);

    // Held req_valid with alternating loads/stores
    w0 = wr_total; r0 = rsp_total;
    accepted = 0; n_rsp = 0; busy = 0;
    set_req(0);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 40 && (accepted < 4 || n_rsp < 4); c++) begin
      if (bus.rsp_valid && n_rsp < 4) begin
        got[n_rsp] = bus.rsp_rdata;
        n_rsp++;
      end
      fire = bus.req_ready && bus.req_valid;
      if (bus.req_valid && !bus.req_ready) busy++;
      @(posedge clk);
      #1;
      if (fire) begin
        accepted++;
        if (accepted < 4) set_req(accepted);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stream.nrsp", n_rsp, 4);
    check("stream.rsp_total", rsp_total - r0, 4);
    check("stream.writes", wr_total - w0, 2);
    check("stream.busy", {31'd0, busy > 0}, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < n_rsp) check($sformatf("stream.rdata%0d", i), got[i], s_exp[i]);
    end
    expect_load("stream.lw40", F3_W, 12'h040, 32'hCAFE990D);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
